// File: rtl/z80_bank_bridge_pkg.sv
// z80_bank_bridge_pkg: shared widths and sequencer state encoding for the Z80-to-68k bank bridge.
package z80_bank_bridge_pkg;
   localparam int BANK_W = 9;
   localparam int ZA_W = 15;
   localparam int VA_W = 23;
   typedef enum logic [2:0] {IDLE, REQ, OWN, STRB, REL, DONE} state_t;
endpackage

// File: rtl/z80_bank_reg.sv
// z80_bank_reg: 9-bit bank register loaded serially, one bit per Z80 bank write.
module z80_bank_reg
   import z80_bank_bridge_pkg::*;
(
   input  logic              MCLK,
   input  logic              RESET,
   input  logic              bank_wr,
   input  logic              z_d0,
   output logic [BANK_W-1:0] bank
);
   always_ff @(posedge MCLK)
      if (RESET) bank <= '0;
      else if (bank_wr) bank <= {z_d0, bank[BANK_W-1:1]};
endmodule

// File: rtl/z80_bank_bridge.sv
// z80_bank_bridge: steals the 68k bus for one byte cycle per Z80 bank-window access, stalling the Z80 with WAIT.
module z80_bank_bridge
   import z80_bank_bridge_pkg::*;
#(
   parameter int SETUP_CYC = 1,
   parameter int TIMEOUT = 255
) (
   input  logic            MCLK,
   input  logic            RESET,
   input  logic            z_win,
   input  logic            z_rd,
   input  logic [14:0]     z_a,
   input  logic [7:0]      z_din,
   input  logic            bank_wr,
   input  logic            z_d0,
   input  logic            bg,
   input  logic            as_busy,
   input  logic            bgack_ext,
   input  logic            dtack,
   input  logic [15:0]     vd_in,
   output logic            z_wait,
   output logic            br,
   output logic            bgack,
   output logic            as,
   output logic            uds,
   output logic            lds,
   output logic            rw,
   output logic [22:0]     va,
   output logic [15:0]     vd_out,
   output logic [7:0]      z_dout,
   output logic            err
);
   localparam logic [2:0] SETUP_W = 3'(SETUP_CYC);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   state_t state;
   logic [BANK_W-1:0] bank;
   logic [2:0] scnt;
   logic [7:0] tcnt;
   logic a0;
   z80_bank_reg u_bank (
      .MCLK(MCLK),
      .RESET(RESET),
      .bank_wr(bank_wr),
      .z_d0(z_d0),
      .bank(bank)
   );
   assign z_wait = (state == IDLE) ? z_win : (state != DONE);
   // tcnt counts completed STRB cycles, so the last allowed cycle sees TIMEOUT-1
   assign err = (state == STRB) && !dtack && (tcnt == TMO_LAST) && !RESET;
   always_ff @(posedge MCLK)
      if (RESET) begin
         state <= IDLE;
         br <= 1'b0;
         bgack <= 1'b0;
         as <= 1'b0;
         uds <= 1'b0;
         lds <= 1'b0;
         rw <= 1'b0;
         va <= '0;
         vd_out <= '0;
         z_dout <= '0;
         a0 <= 1'b0;
         scnt <= '0;
         tcnt <= '0;
      end else
         case (state)
            IDLE: if (z_win) begin
               state <= REQ;
               br <= 1'b1;
            end
            REQ: if (bg && !as_busy && !bgack_ext) begin
               state <= OWN;
               br <= 1'b0;
               bgack <= 1'b1;
               va <= {bank, z_a[14:1]};
               rw <= z_rd;
               vd_out <= {z_din, z_din};
               a0 <= z_a[0];
               scnt <= 3'd1;
            end
            OWN: if (scnt >= SETUP_W) begin
               state <= STRB;
               as <= 1'b1;
               uds <= !a0;
               lds <= a0;
               tcnt <= '0;
            end else scnt <= scnt + 3'd1;
            STRB: if (dtack || tcnt >= TMO_LAST) begin
               state <= REL;
               as <= 1'b0;
               uds <= 1'b0;
               lds <= 1'b0;
               z_dout <= !dtack ? 8'hFF : !rw ? z_dout : a0 ? vd_in[7:0] : vd_in[15:8];
            end else tcnt <= tcnt + 8'd1;
            REL: begin
               state <= DONE;
               bgack <= 1'b0;
            end
            DONE: if (!z_win) state <= IDLE;
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_z80_bank_bridge.sv
// tb_z80_bank_bridge: random bank-window transactions checked against a cycle-level transaction model.
module tb_z80_bank_bridge;
   localparam int SETUP = 1;
   localparam int TMO = 4;
   logic MCLK = 0, RESET = 1, z_win = 0, z_rd = 0, bank_wr = 0, z_d0 = 0;
   logic bg = 0, as_busy = 0, bgack_ext = 0, dtack = 0;
   logic [14:0] z_a = '0;
   logic [7:0] z_din = '0;
   logic [15:0] vd_in = '0;
   logic z_wait, br, bgack, as, uds, lds, rw, err;
   logic [22:0] va;
   logic [15:0] vd_out;
   logic [7:0] z_dout;
   int vectors = 0, miscompares = 0;
   int bank_m = 0;
   logic [7:0] zdout_m = 8'h00;

   z80_bank_bridge #(.SETUP_CYC(SETUP), .TIMEOUT(TMO)) dut (
      .MCLK(MCLK), .RESET(RESET), .z_win(z_win), .z_rd(z_rd), .z_a(z_a), .z_din(z_din),
      .bank_wr(bank_wr), .z_d0(z_d0), .bg(bg), .as_busy(as_busy), .bgack_ext(bgack_ext),
      .dtack(dtack), .vd_in(vd_in), .z_wait(z_wait), .br(br), .bgack(bgack), .as(as),
      .uds(uds), .lds(lds), .rw(rw), .va(va), .vd_out(vd_out), .z_dout(z_dout), .err(err)
   );

   always #5 MCLK = ~MCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic bank_shift(input bit d);
      @(negedge MCLK);
      bank_wr = 1;
      z_d0 = d;
      bank_m = (bank_m >> 1) | (int'(d) << 8);
      @(negedge MCLK);
      bank_wr = 0;
   endtask

   // gkind picks what holds off the grant for gd cycles: 0 = bg low, 1 = as_busy, 2 = bgack_ext
   task automatic txn(input bit rd, input logic [14:0] a, input logic [7:0] din, input logic [15:0] vd,
                      input int gd, input int gkind, input int dd, input bit wr_own, input bit rst_strb);
      bit to;
      int s, de, dn;
      logic [22:0] eva;
      logic [7:0] edout;
      to = dd >= TMO;
      de = to ? TMO - 1 : dd;
      s = 2 + gd + SETUP;
      dn = s + de + 2;
      eva = 23'((bank_m << 14) | int'(a >> 1));
      edout = to ? 8'hFF : !rd ? zdout_m : a[0] ? vd[7:0] : vd[15:8];
      for (int n = 0; n <= dn + 1; n++) begin
         @(negedge MCLK);
         z_win = (n <= dn) && !(rst_strb && n >= s);
         z_rd = rd;
         z_a = a;
         z_din = din;
         vd_in = vd;
         bg = (gkind != 0) || (n >= 1 + gd);
         as_busy = (gkind == 1) && (n < 1 + gd);
         bgack_ext = (gkind == 2) && (n < 1 + gd);
         dtack = !to && (n == s + dd);
         bank_wr = wr_own && (n == 2 + gd);
         z_d0 = 1'($urandom);
         if (rst_strb && n == s) RESET = 1;
         #1;
         if (rst_strb && n == s + 1) begin
            check("rst_br", br, 0);
            check("rst_bgack", bgack, 0);
            check("rst_as", as, 0);
            check("rst_strobes", {uds, lds}, 0);
            check("rst_wait", z_wait, 0);
            check("rst_zdout", z_dout, 0);
            RESET = 0;
            bank_m = 0;
            zdout_m = 0;
            return;
         end
         check("wait", z_wait, n < dn);
         check("err", err, to && n == s + TMO - 1);
         if (n >= 1 && n < 2 + gd) begin
            check("req_br", br, 1);
            check("req_bgack", bgack, 0);
         end
         if (n >= 2 + gd && n < s) begin
            check("own_bgack", bgack, 1);
            check("own_br", br, 0);
            check("own_as", as, 0);
         end
         if (n == s) begin
            check("strb_as", as, 1);
            check("strb_uds", uds, !a[0]);
            check("strb_lds", lds, a[0]);
            check("strb_va", va, eva);
            check("strb_rw", rw, rd);
            if (!rd) check("strb_vdout", vd_out, {din, din});
         end
         if (n == s + de + 1) begin
            check("rel_strobes", {as, uds, lds}, 0);
            check("rel_bgack", bgack, 1);
         end
         if (n == dn) begin
            check("done_bgack", bgack, 0);
            check("done_br", br, 0);
            check("done_va", va, eva);
            check("done_zdout", z_dout, edout);
         end
         if (bank_wr) bank_m = (bank_m >> 1) | (int'(z_d0) << 8);
      end
      zdout_m = edout;
   endtask

   initial begin
      logic [8:0] pat;
      pat = 9'b100000001;
      repeat (2) @(negedge MCLK);
      RESET = 0;
      #1;
      check("reset_outs", {z_wait, br, bgack, as, uds, lds, rw, err}, 0);
      check("reset_va", va, 0);
      check("reset_zdout", z_dout, 0);
      for (int i = 0; i < 9; i++) bank_shift(pat[i]);
      txn(1, 15'h1234, 8'h00, 16'hC3A5, 0, 0, 0, 0, 0);
      txn(1, 15'h0001, 8'h00, 16'h34AB, 0, 0, 0, 0, 0);
      txn(1, 15'h2223, 8'h00, 16'h1111, 10, 1, 0, 0, 0);
      txn(0, 15'h0F00, 8'h5A, 16'h0000, 0, 0, 1, 0, 0);
      txn(0, 15'h0F01, 8'h5A, 16'h0000, 2, 2, 0, 0, 0);
      txn(1, 15'h4445, 8'h00, 16'h9876, 1, 0, 9, 0, 0);
      txn(1, 15'h7770, 8'h00, 16'h5555, 0, 0, 3, 0, 1);
      txn(1, 15'h1357, 8'h00, 16'hBEEF, 0, 0, 0, 1, 0);
      txn(1, 15'h1357, 8'h00, 16'hCAFE, 0, 0, 0, 0, 0);
      for (int t = 0; t < 40; t++) begin
         int k;
         k = $urandom_range(0, 3);
         for (int j = 0; j < k; j++) bank_shift(1'($urandom));
         txn(1'($urandom), 15'($urandom), 8'($urandom), 16'($urandom), $urandom_range(0, 4),
             $urandom_range(0, 2), $urandom_range(0, 6), 1'($urandom), 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/z80_bank_bridge.md
# z80_bank_bridge

Sequencer that lets the Z80 reach the 68k bus through the 32 KB bank window. It holds the 9-bit bank register and, on a window access, runs the full bus-steal sequence: BR/BG/BGACK handshake, one byte-wide 68k cycle, DTACK wait with timeout, and release. It stalls the Z80 with WAIT for the whole sequence. It sits between the Z80 decode logic and the 68k bus drivers inside the bus-arbiter partition. All signals are active-high; pad inversion happens outside.

## Interface
- SETUP_CYC, 1: cycles BGACK and address are held before AS is asserted (1..7).
- TIMEOUT, 255: max STRB cycles waiting for DTACK (1..255).

- MCLK  in  1  master clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high.
- z_win  in  1  Z80 memory request in 0x8000–0xFFFF; level, held until WAIT drops.
- z_rd  in  1  1 = read, 0 = write; valid with z_win.
- z_a  in  15  Z80 address bits 14:0.
- z_din  in  8  Z80 write data.
- bank_wr  in  1  one-cycle pulse: Z80 write to the bank register.
- z_d0  in  1  data bit 0 for bank_wr.
- bg  in  1  68k bus grant.
- as_busy  in  1  68k AS currently asserted by another master.
- bgack_ext  in  1  another master holds BGACK.
- dtack  in  1  slave acknowledge.
- vd_in  in  16  68k data bus read value.
- z_wait  out  1  Z80 WAIT.
- br  out  1  bus request.
- bgack  out  1  bus grant acknowledge.
- as  out  1  address strobe.
- uds  out  1  upper data strobe.
- lds  out  1  lower data strobe.
- rw  out  1  1 = read.
- va  out  23  68k address bits 23:1.
- vd_out  out  16  write data.
- z_dout  out  8  read data to the Z80.
- err  out  1  one-cycle pulse on DTACK timeout.

## Operation
- Bank register: on bank_wr, `bank <= {z_d0, bank[8:1]}`. Reset value is 0. It shifts in any state. The address is latched on entry to OWN, so a mid-transaction shift does not affect the cycle in progress.
- Address mapping: `va = {bank[8:0], z_a[14:1]}`.
  - z_a[0] = 0 drives uds; z_a[0] = 1 drives lds.
  - vd_out = {z_din, z_din}.
  - On read, z_dout takes vd_in[15:8] when A0 = 0 and vd_in[7:0] when A0 = 1.
- States:
  - IDLE: z_win → REQ.
  - REQ: br = 1. When bg & !as_busy & !bgack_ext → OWN.
  - OWN: br = 0, bgack = 1, va/rw/vd_out are driven. Stay SETUP_CYC cycles → STRB.
  - STRB: as = 1 and the selected strobe = 1.
    - dtack → capture read data, go to REL.
    - Timeout counter reaching TIMEOUT → pulse err, go to REL with z_dout = 0xFF.
  - REL: as = uds = lds = 0, bgack stays 1, for one cycle → DONE.
  - DONE: bgack = 0. Stay until z_win = 0 → IDLE.
- z_wait is combinational: `(state == IDLE & z_win) | (state ∉ {IDLE, DONE})`. WAIT is therefore asserted in the same cycle z_win rises.
- Reset values: all outputs 0, z_dout = 0, bank = 0, state = IDLE.
- RESET mid-operation: the next edge forces IDLE with br, bgack, as and the strobes deasserted. No err pulse is produced.
- A grant condition that drops while in REQ keeps the block in REQ. Once OWN is entered, the block ignores bg.

## Timing
- Uncontended reference case (SETUP_CYC = 1, grant present, dtack in the first STRB cycle):
  - c0: IDLE, z_win seen.
  - c1: REQ.
  - c2: OWN.
  - c3: STRB, dtack.
  - c4: REL.
  - c5: DONE, z_wait = 0, z_dout valid.
- Access latency is 5 cycles plus grant delay plus (SETUP_CYC − 1) plus DTACK delay.
- Registered outputs (br, bgack, as, strobes, va, rw, vd_out) change on the edge that enters the state.
- z_dout is registered on the edge leaving STRB and held until the next capture.
- Timeout counter:
  - Cleared on STRB entry.
  - Increments each STRB cycle without dtack.
  - With TIMEOUT = N, err pulses in the Nth STRB cycle.
  - dtack in the same cycle as the terminal count wins: no err.
- The SETUP_CYC counter is 3 bits and the timeout counter is 8 bits. Neither counter wraps; both reload on state entry.

## Structure
- Package z80_bank_bridge_pkg: state enum (IDLE, REQ, OWN, STRB, REL, DONE), BANK_W = 9, address-width constants.
- Sub-module z80_bank_reg holds the 9-bit shift register with the bank_wr/z_d0 interface.
- The FSM, counters and datapath latches stay in the top module.

## Test plan
- Bank load: nine bank_wr pulses with z_d0 = 1,0,0,0,0,0,0,0,1 → bank = 0x101. A read at z_a = 0x1234 then drives va = {9'h101, 14'h091A} and uds = 1.
- Uncontended read, z_a[0] = 1, vd_in = 0xAB, dtack in the first STRB cycle → lds only, z_dout = 0xAB, z_wait drops exactly 5 cycles after z_win rises.
- Contended: as_busy = 1 for 10 cycles after br → bgack stays 0 until the cycle after as_busy falls, and br stays held throughout.
- Write with z_din = 0x5A → rw = 0, vd_out = 0x5A5A, the strobe follows A0.
- Timeout with TIMEOUT = 4 and no dtack → err pulses once in the 4th STRB cycle, z_dout = 0xFF, bus is released, WAIT drops.
- RESET asserted during STRB → next cycle shows as = bgack = br = 0, state IDLE, bank = 0; bank_wr during OWN shifts bank but the latched va is unchanged.
